// File: rtl/ariane_pkg.sv
// Shared core constants: event indices for the performance counters and the
// software access target encoding used by hpm_counters.
package ariane_pkg;

  localparam int unsigned NR_COMMIT_PORTS = 2;

  // Event input indices; index 0 is reserved and never counts.
  localparam int unsigned EVT_NONE        = 0;
  localparam int unsigned EVT_ICACHE_MISS = 1;
  localparam int unsigned EVT_DCACHE_MISS = 2;
  localparam int unsigned EVT_ITLB_MISS   = 3;
  localparam int unsigned EVT_DTLB_MISS   = 4;
  localparam int unsigned EVT_LOAD        = 5;
  localparam int unsigned EVT_STORE       = 6;
  localparam int unsigned EVT_BRANCH      = 7;
  localparam int unsigned EVT_CALL        = 8;
  localparam int unsigned EVT_RET         = 9;
  localparam int unsigned EVT_MISPREDICT  = 10;
  localparam int unsigned EVT_EXCEPTION   = 11;
  localparam int unsigned EVT_ERET        = 12;
  localparam int unsigned EVT_SB_FULL     = 13;
  localparam int unsigned EVT_IF_EMPTY    = 14;

  typedef enum logic [1:0] {
    SEL_COUNTER  = 2'd0,
    SEL_EVENT    = 2'd1,
    SEL_INHIBIT  = 2'd2,
    SEL_OVERFLOW = 2'd3
  } hpm_sel_e;

endpackage

// File: rtl/hpm_counter_slice.sv
// One performance counter: value, event select, inhibit bit and sticky
// overflow flag. Software writes win over the same-cycle increment.
module hpm_counter_slice #(
  parameter int unsigned CNT_WIDTH = 64,
  parameter int unsigned NR_EVENTS = 16,
  parameter int unsigned EVT_W     = 2,
  parameter int unsigned SEL_W     = $clog2(NR_EVENTS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       debug_mode,
  input  logic [NR_EVENTS*EVT_W-1:0] events,
  input  logic                       cnt_we,
  input  logic [CNT_WIDTH-1:0]       cnt_wdata,
  input  logic                       sel_we,
  input  logic [SEL_W-1:0]           sel_wdata,
  input  logic                       inh_we,
  input  logic                       inh_wdata,
  input  logic                       ovf_clr,
  output logic [CNT_WIDTH-1:0]       count,
  output logic [SEL_W-1:0]           evt_sel,
  output logic                       inhibit,
  output logic                       ovf
);

  logic [EVT_W-1:0]   inc;
  logic [CNT_WIDTH:0] sum;
  logic               count_en;
  logic               ovf_set;
  logic               evt0_unused;

  // Event 0 is reserved, so its increment bits are never consumed.
  assign evt0_unused = ^events[EVT_W-1:0];

  always_comb begin
    // NOTE: default assignment first so no path leaves inc unassigned (no latch).
    inc = '0;
    for (int e = 1; e < int'(NR_EVENTS); e++) begin
      if (evt_sel == SEL_W'(e)) inc = events[e*EVT_W +: EVT_W];
    end
  end

  assign count_en = !debug_mode && !inhibit;
  assign sum      = {1'b0, count} + (CNT_WIDTH+1)'(inc);
  assign ovf_set  = count_en && !cnt_we && sum[CNT_WIDTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count   <= '0;
      evt_sel <= '0;
      inhibit <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      if (cnt_we)        count <= cnt_wdata;
      else if (count_en) count <= sum[CNT_WIDTH-1:0];

      if (sel_we) evt_sel <= sel_wdata;
      if (inh_we) inhibit <= inh_wdata;

      // A same-cycle overflow beats a write-1-to-clear.
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/hpm_counters.sv
// Bank of NR_COUNTERS programmable event counters with a software access port.
// Optional macro HPM_OVERFLOW_IRQ_EN enables the registered overflow interrupt.
module hpm_counters
  import ariane_pkg::*;
#(
  parameter int unsigned NR_COUNTERS = 8,
  parameter int unsigned CNT_WIDTH   = 64,
  parameter int unsigned NR_EVENTS   = 16,
  parameter int unsigned EVT_W       = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       debug_mode_i,
  input  logic [4:0]                 addr_i,
  input  logic [1:0]                 sel_i,
  input  logic                       we_i,
  input  logic [63:0]                data_i,
  output logic [63:0]                data_o,
  input  logic [NR_EVENTS*EVT_W-1:0] events_i,
  output logic                       irq_o
);

  localparam int unsigned SEL_W = $clog2(NR_EVENTS);

  hpm_sel_e               sel;
  logic [CNT_WIDTH-1:0]   count   [NR_COUNTERS];
  logic [SEL_W-1:0]       evt_sel [NR_COUNTERS];
  logic [NR_COUNTERS-1:0] inhibit;
  logic [NR_COUNTERS-1:0] ovf;
  logic                   data_unused;

  assign sel         = hpm_sel_e'(sel_i);
  assign data_unused = ^data_i;

  // Index i < NR_COUNTERS, so out-of-range addresses match no slice.
  for (genvar i = 0; i < int'(NR_COUNTERS); i++) begin : g_slice
    logic hit;
    assign hit = (addr_i == 5'(i));

    hpm_counter_slice #(
      .CNT_WIDTH (CNT_WIDTH),
      .NR_EVENTS (NR_EVENTS),
      .EVT_W     (EVT_W),
      .SEL_W     (SEL_W)
    ) u_slice (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .debug_mode (debug_mode_i),
      .events     (events_i),
      .cnt_we     (we_i && sel == SEL_COUNTER && hit),
      .cnt_wdata  (data_i[CNT_WIDTH-1:0]),
      .sel_we     (we_i && sel == SEL_EVENT && hit),
      .sel_wdata  (data_i[SEL_W-1:0]),
      .inh_we     (we_i && sel == SEL_INHIBIT),
      .inh_wdata  (data_i[i]),
      .ovf_clr    (we_i && sel == SEL_OVERFLOW && data_i[i]),
      .count      (count[i]),
      .evt_sel    (evt_sel[i]),
      .inhibit    (inhibit[i]),
      .ovf        (ovf[i])
    );
  end

  always_comb begin
    data_o = '0;
    case (sel)
      SEL_COUNTER: begin
        for (int i = 0; i < int'(NR_COUNTERS); i++) begin
          if (addr_i == 5'(i)) data_o = 64'(count[i]);
        end
      end
      SEL_EVENT: begin
        for (int i = 0; i < int'(NR_COUNTERS); i++) begin
          if (addr_i == 5'(i)) data_o = 64'(evt_sel[i]);
        end
      end
      SEL_INHIBIT:  data_o = 64'(inhibit);
      SEL_OVERFLOW: data_o = 64'(ovf);
      default:      data_o = '0;
    endcase
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= |(ovf & ~inhibit);
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpm_counters.sv
// Self-checking bench for hpm_counters: a vector table for reset/decode
// behaviour plus hand sequences for counting, overflow, priority and debug.
module tb_hpm_counters;

  localparam int unsigned NR_COUNTERS = 4;
  localparam int unsigned CNT_WIDTH   = 32;
  localparam int unsigned NR_EVENTS   = 12;
  localparam int unsigned EVT_W       = 2;
  localparam int unsigned EV_W        = NR_EVENTS * EVT_W;

`ifdef HPM_OVERFLOW_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            debug_mode_i = 1'b0;
  logic [4:0]      addr_i = '0;
  logic [1:0]      sel_i = '0;
  logic            we_i = 1'b0;
  logic [63:0]     data_i = '0;
  logic [63:0]     data_o;
  logic [EV_W-1:0] events_i = '0;
  logic            irq_o;

  hpm_counters #(
    .NR_COUNTERS (NR_COUNTERS),
    .CNT_WIDTH   (CNT_WIDTH),
    .NR_EVENTS   (NR_EVENTS),
    .EVT_W       (EVT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .debug_mode_i (debug_mode_i),
    .addr_i       (addr_i),
    .sel_i        (sel_i),
    .we_i         (we_i),
    .data_i       (data_i),
    .data_o       (data_o),
    .events_i     (events_i),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [63:0] data;
    bit          chk_irq;
    logic        irq;
  } exp_t;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic        we;
    logic [63:0] data;
    logic [63:0] exp;
    string       name;
  } vec_t;

  exp_t            sb[$];
  vec_t            vecs[17];
  int              n_checks = 0;
  int              n_errors = 0;
  bit              chk_valid = 1'b0;
  logic [EV_W-1:0] cur_ev = '0;
  logic            cur_dbg = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EV_W-1:0] ev(input int idx, input int amt);
    logic [EV_W-1:0] v;
    v = '0;
    v[idx*EVT_W +: EVT_W] = EVT_W'(amt);
    return v;
  endfunction

  // One access cycle: drive just after the edge, read is checked at the negedge.
  task automatic step(input logic [1:0] s, input logic [4:0] a, input logic w,
                      input logic [63:0] d, input string nm, input logic [63:0] exp,
                      input bit ci = 1'b0, input logic ei = 1'b0);
    sel_i        = s;
    addr_i       = a;
    we_i         = w;
    data_i       = d;
    events_i     = cur_ev;
    debug_mode_i = cur_dbg;
    sb.push_back('{nm, exp, ci, ei});
    chk_valid = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (chk_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, data_o, e.data);
        if (e.chk_irq) check({e.name, "_irq"}, {63'b0, irq_o}, {63'b0, e.irq});
      end
    end
  end

  initial begin
    vecs[0]  = '{2'd2, 5'd0, 1'b0, 64'h0, 64'hF, "rst_inh"};
    vecs[1]  = '{2'd3, 5'd0, 1'b0, 64'h0, 64'h0, "rst_ovf"};
    vecs[2]  = '{2'd0, 5'd0, 1'b0, 64'h0, 64'h0, "rst_cnt0"};
    vecs[3]  = '{2'd0, 5'd1, 1'b0, 64'h0, 64'h0, "rst_cnt1"};
    vecs[4]  = '{2'd0, 5'd2, 1'b0, 64'h0, 64'h0, "rst_cnt2"};
    vecs[5]  = '{2'd0, 5'd3, 1'b0, 64'h0, 64'h0, "rst_cnt3"};
    vecs[6]  = '{2'd1, 5'd1, 1'b0, 64'h0, 64'h0, "rst_sel1"};
    vecs[7]  = '{2'd1, 5'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF5, 64'h0, "sel_wr_pre"};
    vecs[8]  = '{2'd1, 5'd0, 1'b0, 64'h0, 64'h5, "sel_lowbits"};
    vecs[9]  = '{2'd2, 5'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hF, "inh_wr_pre"};
    vecs[10] = '{2'd2, 5'd0, 1'b0, 64'h0, 64'hE, "inh_mask"};
    vecs[11] = '{2'd0, 5'd4, 1'b1, 64'hDEAD, 64'h0, "oor_wr"};
    vecs[12] = '{2'd0, 5'd4, 1'b0, 64'h0, 64'h0, "oor_rd"};
    vecs[13] = '{2'd1, 5'd4, 1'b1, 64'h5, 64'h0, "oor_sel_wr"};
    vecs[14] = '{2'd1, 5'd4, 1'b0, 64'h0, 64'h0, "oor_sel_rd"};
    vecs[15] = '{2'd0, 5'd0, 1'b0, 64'h0, 64'h0, "cnt0_untouched"};
    vecs[16] = '{2'd0, 5'd3, 1'b0, 64'h0, 64'h0, "cnt3_untouched"};

    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    foreach (vecs[i]) step(vecs[i].sel, vecs[i].addr, vecs[i].we, vecs[i].data, vecs[i].name, vecs[i].exp);

    // Counter0 counts event 5 at 2 per cycle.
    cur_ev = ev(5, 2);
    for (int k = 0; k < 10; k++) step(2'd0, 5'd0, 1'b0, 64'h0, "cnt0_run", 64'(2 * k));
    cur_ev = '0;
    step(2'd0, 5'd0, 1'b0, 64'h0, "cnt0_total", 64'd20);
    for (int k = 1; k < 4; k++) step(2'd0, 5'(k), 1'b0, 64'h0, "others_zero", 64'h0);

    // Overflow of a 32-bit counter by a multi-unit increment.
    step(2'd1, 5'd1, 1'b1, 64'd3, "sel1_wr", 64'h0);
    step(2'd0, 5'd1, 1'b1, 64'h1234_5678_FFFF_FFFE, "cnt1_preset", 64'h0);
    step(2'd2, 5'd0, 1'b1, 64'hC, "inh_wr2", 64'hE);
    cur_ev = ev(3, 3);
    step(2'd0, 5'd1, 1'b0, 64'h0, "cnt1_pre_ovf", 64'hFFFF_FFFE, 1'b1, 1'b0);
    cur_ev = '0;
    step(2'd0, 5'd1, 1'b0, 64'h0, "cnt1_wrapped", 64'h1, 1'b1, 1'b0);
    step(2'd3, 5'd0, 1'b0, 64'h0, "ovf1_set", 64'h2, 1'b1, IRQ_EXP);

    // Write-1-to-clear, then a set and a clear of the same flag together.
    step(2'd3, 5'd0, 1'b1, 64'hF, "ovf_w1c_pre", 64'h2);
    step(2'd0, 5'd1, 1'b1, 64'hFFFF_FFFF, "cnt1_max", 64'h1);
    cur_ev = ev(3, 1);
    step(2'd3, 5'd0, 1'b1, 64'h2, "ovf_cleared", 64'h0);
    cur_ev = '0;
    step(2'd3, 5'd0, 1'b0, 64'h0, "ovf_set_wins", 64'h2);
    step(2'd0, 5'd1, 1'b0, 64'h0, "cnt1_zero", 64'h0);

    // Inhibit write uses the old setting this cycle; write beats increment.
    step(2'd1, 5'd2, 1'b1, 64'd7, "sel2_wr", 64'h0);
    cur_ev = ev(7, 1);
    step(2'd2, 5'd0, 1'b1, 64'h8, "inh_wr3", 64'hC);
    step(2'd0, 5'd2, 1'b0, 64'h0, "cnt2_old_inh", 64'd0);
    step(2'd0, 5'd2, 1'b0, 64'h0, "cnt2_run", 64'd1);
    step(2'd0, 5'd2, 1'b0, 64'h0, "cnt2_run", 64'd2);
    step(2'd0, 5'd2, 1'b1, 64'd100, "cnt2_wr_old", 64'd3);
    step(2'd0, 5'd2, 1'b0, 64'h0, "cnt2_wr_new", 64'd100);
    cur_ev = '0;
    step(2'd0, 5'd2, 1'b0, 64'h0, "cnt2_after", 64'd101);

    // Debug freezes counting but not software writes.
    cur_ev  = '1;
    cur_dbg = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) step(2'd0, 5'd0, 1'b1, 64'h55, "dbg_wr", 64'd20);
      else        step(2'd0, 5'd0, 1'b0, 64'h0, "dbg_hold", (k < 3) ? 64'd20 : 64'h55);
    end
    cur_ev  = '0;
    cur_dbg = 1'b0;
    step(2'd0, 5'd2, 1'b0, 64'h0, "dbg_cnt2", 64'd101);
    step(2'd0, 5'd1, 1'b0, 64'h0, "dbg_cnt1", 64'd0);
    step(2'd3, 5'd0, 1'b0, 64'h0, "dbg_ovf", 64'h2);

    // Selects 0 and >= NR_EVENTS never count.
    step(2'd1, 5'd3, 1'b1, 64'd13, "sel3_wr", 64'h0);
    step(2'd2, 5'd0, 1'b1, 64'h0, "inh_all_on", 64'h8);
    cur_ev = '1;
    step(2'd1, 5'd3, 1'b0, 64'h0, "sel3_rd", 64'd13);
    cur_ev = '0;
    step(2'd0, 5'd3, 1'b0, 64'h0, "sel_oor_none", 64'h0);
    step(2'd0, 5'd0, 1'b0, 64'h0, "cnt0_plus3", 64'h58);
    step(2'd0, 5'd2, 1'b0, 64'h0, "cnt2_plus3", 64'd104);
    step(2'd1, 5'd0, 1'b1, 64'h0, "sel0_clr", 64'h5);
    cur_ev = ev(0, 3);
    step(2'd0, 5'd0, 1'b0, 64'h0, "evt0_pre", 64'h58);
    cur_ev = '0;
    step(2'd0, 5'd0, 1'b0, 64'h0, "evt0_none", 64'h58);

    chk_valid = 1'b0;
    check("sb_drain", 64'(sb.size()), 64'd0);

    // Asynchronous reset takes effect without a clock edge.
    sel_i  = 2'd2;
    we_i   = 1'b0;
    #1 rst_ni = 1'b0;
    #1 check("async_rst_inh", data_o, 64'hF);
    sel_i = 2'd3;
    #1 check("async_rst_ovf", data_o, 64'h0);
    check("async_rst_irq", {63'b0, irq_o}, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
